dmem_lsu_ctrl: RTL and testbench

- CPU-side initiator for the data port of the dual-port word memory. That memory has a synchronous 1-cycle read, a word-only write enable and a 14-bit word address.
- Accepts byte, half and word loads/stores from the execute stage on a valid/ready handshake.
- Sub-word stores are built as read-modify-write sequences. Loads are sign- or zero-extended.
- Misaligned accesses are rejected with an error response.

---
 rtl/dmem_lsu_ctrl_pkg.sv | 38 +++
 rtl/dmem_lsu_ctrl_if.sv | 37 +++
 rtl/dmem_lsu_ctrl_lane_fmt.sv | 56 +++++
 rtl/dmem_lsu_ctrl.sv | 156 +++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_lsu_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | lsu_pkg : shared types and helpers for the dmem_lsu_ctrl load/store unit  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

    localparam int LSU_LANES  = 4;
    localparam int LSU_BYTE_W = 8;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LD_WAIT = 2'd1,
        ST_RMW     = 2'd2,
        ST_DONE    = 2'd3
    } lsu_state_e;

    // Illegal size is treated as misaligned so a single flag drives the error path.
    function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off;
            default: return 1'b1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lsu_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | dmem_lsu_ctrl_if : request/response and memory-port bundle of the LSU     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface dmem_lsu_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

`default_nettype wire

// File: rtl/dmem_lsu_ctrl_lane_fmt.sv
// +--------------------------------------------------------------------------+
// | lsu_lane_fmt : combinational load extract/extend and store lane merge     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module lsu_lane_fmt
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic [DATA_W-1:0] ld_word,
    input  wire logic [1:0]        offset,
    input  lsu_size_e              size,
    input  wire logic              is_unsigned,
    input  wire logic [DATA_W-1:0] st_old,
    input  wire logic [DATA_W-1:0] st_new,
    output logic      [DATA_W-1:0] ld_data,
    output logic      [DATA_W-1:0] st_data
);

    logic [LSU_BYTE_W-1:0]   w_byte;
    logic [2*LSU_BYTE_W-1:0] w_half;
    logic                    w_sign;

    always_comb begin
        w_byte  = ld_word[{offset, 3'b000} +: LSU_BYTE_W];
        w_half  = ld_word[{offset[1], 4'b0000} +: 2*LSU_BYTE_W];
        w_sign  = 1'b0;
        ld_data = ld_word;
        case (size)
            SZ_B: begin
                w_sign  = ~is_unsigned & w_byte[LSU_BYTE_W-1];
                ld_data = {{(DATA_W-LSU_BYTE_W){w_sign}}, w_byte};
            end
            SZ_H: begin
                w_sign  = ~is_unsigned & w_half[2*LSU_BYTE_W-1];
                ld_data = {{(DATA_W-2*LSU_BYTE_W){w_sign}}, w_half};
            end
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        st_data = st_old;
        case (size)
            SZ_B:    st_data[{offset, 3'b000} +: LSU_BYTE_W]       = st_new[LSU_BYTE_W-1:0];
            SZ_H:    st_data[{offset[1], 4'b0000} +: 2*LSU_BYTE_W] = st_new[2*LSU_BYTE_W-1:0];
            SZ_W:    st_data = st_new;
            default: st_data = st_old;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_lsu_ctrl.sv
// +--------------------------------------------------------------------------+
// | dmem_lsu_ctrl : data-port load/store initiator with sub-word RMW stores;  |
// | define LSU_PERF_EN to add load/store performance counters.               |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module dmem_lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
`ifdef LSU_PERF_EN
    output logic [31:0]      perf_loads,
    output logic [31:0]      perf_stores,
`endif
    dmem_lsu_ctrl_if.slave   bus
);

    lsu_state_e        r_state;
    logic [ADDR_W-1:0] r_waddr;
    logic [1:0]        r_off;
    lsu_size_e         r_size;
    logic              r_unsigned;
    logic [DATA_W-1:0] r_wdata;

    lsu_size_e         w_size;
    logic              w_bad;
    logic              w_ready;
    logic              w_accept;
    logic              w_word_st;
    logic              w_load_done;
    logic              w_store_done;
    logic [DATA_W-1:0] w_ld_data;
    logic [DATA_W-1:0] w_st_data;
    logic              w_unused;

    assign w_size       = lsu_size_e'(bus.req_size);
    assign w_bad        = lsu_misaligned(w_size, bus.req_addr[1:0]);
    assign w_ready      = rst_n && (r_state == ST_IDLE);
    assign w_accept     = bus.req_valid && w_ready;
    assign w_word_st    = w_accept && bus.req_we && (w_size == SZ_W) && !w_bad;
    assign w_load_done  = (r_state == ST_LD_WAIT);
    assign w_store_done = w_word_st || (r_state == ST_RMW);
    assign w_unused     = &{1'b0, bus.req_addr[31:ADDR_W+2]};

    lsu_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
        .ld_word     (bus.mem_rdata),
        .offset      (r_off),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .st_old      (bus.mem_rdata),
        .st_new      (r_wdata),
        .ld_data     (w_ld_data),
        .st_data     (w_st_data)
    );

    // Memory-port outputs are combinational so a word store and the first read
    // of a sub-word store both hit the memory on the accept edge.
    always_comb begin
        bus.req_ready = w_ready;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    bus.mem_addr = bus.req_addr[ADDR_W+1:2];
                    if (w_word_st) begin
                        bus.mem_we    = 1'b1;
                        bus.mem_wdata = bus.req_wdata;
                    end
                end
                ST_RMW: begin
                    bus.mem_addr  = r_waddr;
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = w_st_data;
                end
                default: bus.mem_addr = r_waddr;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_waddr        <= '0;
            r_off          <= '0;
            r_size         <= SZ_B;
            r_unsigned     <= 1'b0;
            r_wdata        <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_waddr    <= bus.req_addr[ADDR_W+1:2];
                        r_off      <= bus.req_addr[1:0];
                        r_size     <= w_size;
                        r_unsigned <= bus.req_unsigned;
                        r_wdata    <= bus.req_wdata;
                        if (w_bad) begin
                            r_state        <= ST_DONE;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end else if (!bus.req_we) begin
                            r_state <= ST_LD_WAIT;
                        end else if (w_size == SZ_W) begin
                            r_state        <= ST_DONE;
                            bus.resp_valid <= 1'b1;
                        end else begin
                            r_state <= ST_RMW;
                        end
                    end
                end
                ST_LD_WAIT: begin
                    r_state        <= ST_IDLE;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= w_ld_data;
                end
                ST_RMW: begin
                    r_state        <= ST_DONE;
                    bus.resp_valid <= 1'b1;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef LSU_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_loads  <= '0;
            perf_stores <= '0;
        end else begin
            if (w_load_done)  perf_loads  <= perf_loads + 32'd1;
            if (w_store_done) perf_stores <= perf_stores + 32'd1;
        end
    end
`else
    logic w_unused_perf;
    assign w_unused_perf = w_load_done ^ w_store_done;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_dmem_lsu_ctrl : directed self-checking bench for dmem_lsu_ctrl         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dmem_lsu_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [31:0] mem [0:16383];

    dmem_lsu_ctrl_if #(.DATA_W(32), .ADDR_W(14)) bus ();

`ifdef LSU_PERF_EN
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
`endif

    dmem_lsu_ctrl #(.DATA_W(32), .ADDR_W(14)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef LSU_PERF_EN
        .perf_loads  (perf_loads),
        .perf_stores (perf_stores),
`endif
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: synchronous write, 1-cycle synchronous read.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge; the accept cycle is cycle 0.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err,
                          output int lat, output int wes, output logic we0);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        rd  = '0;
        err = 1'b0;
        lat = -1;
        #1;
        check_eq("ready", {31'd0, bus.req_ready}, 32'd1);
        we0 = bus.mem_we;
        wes = bus.mem_we ? 1 : 0;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_we       = ~we;
        bus.req_size     = 2'b11;
        bus.req_unsigned = ~uns;
        bus.req_addr     = 32'h0000_0040;
        bus.req_wdata    = 32'h5A5A_5A5A;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.mem_we) wes++;
            if (bus.resp_valid) begin
                lat = c;
                rd  = bus.resp_rdata;
                err = bus.resp_err;
            end
        end
        if (lat < 0) begin
            check_eq("timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            if (bus.mem_we) wes++;
            check_eq("pulse", {31'd0, bus.resp_valid}, 32'd0);
        end
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;
    int          wes;
    logic        we0;

    initial begin
        n_checks = 0;
        n_errors = 0;
        mem[4] = 32'h0BAD_F00D;
        mem[5] = 32'h8899_AABB;
        mem[6] = 32'h1122_3344;
        mem[8] = 32'h0000_0000;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0000_0014;
        bus.req_wdata    = 32'hFFFF_FFFF;

        repeat (2) @(negedge clk);
        check_eq("rst_valid", {31'd0, bus.resp_valid}, 32'd0);
        check_eq("rst_err",   {31'd0, bus.resp_err},   32'd0);
        check_eq("rst_rdata", bus.resp_rdata,          32'd0);
        check_eq("rst_ready", {31'd0, bus.req_ready},  32'd0);
        check_eq("rst_we",    {31'd0, bus.mem_we},     32'd0);
        check_eq("rst_wdata", bus.mem_wdata,           32'd0);
        check_eq("rst_addr",  {18'd0, bus.mem_addr},   32'd0);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;

        // Loads from mem[5] = 8899AABB
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, err, lat, wes, we0);
        check_eq("lw_data", rd, 32'h8899_AABB);
        check_eq("lw_err",  {31'd0, err}, 32'd0);
        check_eq("lw_lat",  32'(lat), 32'd2);
        check_eq("lw_we",   32'(wes), 32'd0);
        do_req(1'b0, 2'b00, 1'b0, 32'h16, 32'h0, rd, err, lat, wes, we0);
        check_eq("lb_s", rd, 32'hFFFF_FF99);
        do_req(1'b0, 2'b00, 1'b1, 32'h16, 32'h0, rd, err, lat, wes, we0);
        check_eq("lb_u", rd, 32'h0000_0099);
        do_req(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, rd, err, lat, wes, we0);
        check_eq("lh_s_hi", rd, 32'hFFFF_8899);
        do_req(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, rd, err, lat, wes, we0);
        check_eq("lh_u_lo", rd, 32'h0000_AABB);
        do_req(1'b0, 2'b00, 1'b1, 32'h17, 32'h0, rd, err, lat, wes, we0);
        check_eq("lb_u_3", rd, 32'h0000_0088);

        // Sub-word stores go through read-modify-write
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_1234, rd, err, lat, wes, we0);
        check_eq("sh_mem",   mem[5], 32'h1234_AABB);
        check_eq("sh_wes",   32'(wes), 32'd1);
        check_eq("sh_we0",   {31'd0, we0}, 32'd0);
        check_eq("sh_lat",   32'(lat), 32'd2);
        check_eq("sh_rdata", rd, 32'd0);
        check_eq("sh_err",   {31'd0, err}, 32'd0);
        do_req(1'b1, 2'b00, 1'b0, 32'h14, 32'hFFFF_FFCC, rd, err, lat, wes, we0);
        check_eq("sb_mem", mem[5], 32'h1234_AACC);
        check_eq("sb_wes", 32'(wes), 32'd1);

        // Word store then back-to-back load
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, rd, err, lat, wes, we0);
        check_eq("sw_mem", mem[8], 32'hDEAD_BEEF);
        check_eq("sw_we0", {31'd0, we0}, 32'd1);
        check_eq("sw_wes", 32'(wes), 32'd1);
        check_eq("sw_lat", 32'(lat), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, err, lat, wes, we0);
        check_eq("lw_b2b", rd, 32'hDEAD_BEEF);

        // Errors: no memory access, rdata 0
        do_req(1'b0, 2'b10, 1'b0, 32'h15, 32'h0, rd, err, lat, wes, we0);
        check_eq("lw_mis_err", {31'd0, err}, 32'd1);
        check_eq("lw_mis_rd",  rd, 32'd0);
        check_eq("lw_mis_lat", 32'(lat), 32'd1);
        check_eq("lw_mis_we",  32'(wes), 32'd0);
        do_req(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, rd, err, lat, wes, we0);
        check_eq("lh_mis_err", {31'd0, err}, 32'd1);
        check_eq("lh_mis_we",  32'(wes), 32'd0);
        do_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h0101_0101, rd, err, lat, wes, we0);
        check_eq("sw_mis_err", {31'd0, err}, 32'd1);
        check_eq("sw_mis_we",  32'(wes), 32'd0);
        check_eq("sw_mis_mem", mem[8], 32'hDEAD_BEEF);
        do_req(1'b1, 2'b11, 1'b0, 32'h14, 32'h0202_0202, rd, err, lat, wes, we0);
        check_eq("sz_bad_err", {31'd0, err}, 32'd1);
        check_eq("sz_bad_we",  32'(wes), 32'd0);
        check_eq("err_mem5",   mem[5], 32'h1234_AACC);
        check_eq("err_mem4",   mem[4], 32'h0BAD_F00D);

`ifdef LSU_PERF_EN
        check_eq("perf_ld", perf_loads, 32'd7);
        check_eq("perf_st", perf_stores, 32'd3);
`endif

        // Reset during RMW of a byte store
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h18;
        bus.req_wdata    = 32'h0000_00EE;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("rmw_we_on", {31'd0, bus.mem_we}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rmw_we_off", {31'd0, bus.mem_we}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("rmw_rst_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wes = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.resp_valid) wes++;
        end
        check_eq("rmw_no_resp", 32'(wes), 32'd0);
        check_eq("rmw_mem6",    mem[6], 32'h1122_3344);
        check_eq("rmw_idle",    {31'd0, bus.req_ready}, 32'd1);
`ifdef LSU_PERF_EN
        check_eq("perf_ld_rst", perf_loads, 32'd0);
        check_eq("perf_st_rst", perf_stores, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
